fft_peak_picker: RTL and testbench

//  Downstream of the FFT magnitude BRAM. After each frame is written, scans bins MIN_BIN..2^ADDR_W-1

---
 rtl/fft_pkg.sv | 13 +
 rtl/fft_delay_pipe.sv | 37 +++
 rtl/fft_peak_picker.sv | 154 +++++++++++++++
 tb/tb_fft_peak_picker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types for the FFT post-processing blocks (peak picker, noise tracker).
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } peak_state_t;

  localparam int NO_PEAK = 0;

endpackage

// File: rtl/fft_delay_pipe.sv
// Shift register of {valid, addr} that tracks BRAM read latency so data can be paired with its bin.
module fft_delay_pipe #(
  parameter int LAT = 2,
  parameter int AW  = 10
) (
  input  logic          clk_104mhz,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic          o_busy
);

  logic [LAT-1:0] r_valid;
  logic [AW-1:0]  r_addr [LAT];

  always_ff @(posedge clk_104mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < LAT; i++) r_addr[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_addr[0]  <= i_addr;
      for (int i = 1; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  assign o_valid = r_valid[LAT-1];
  assign o_addr  = r_addr[LAT-1];
  // any entry in flight, used to decide when the last bin has been compared
  assign o_busy  = |r_valid;

endmodule

// File: rtl/fft_peak_picker.sv
// Scans one FFT magnitude frame from BRAM and reports the strongest bin index, or 0 below the noise floor.
//
// state  | meaning
// IDLE   | waiting for a start rising edge; results held
// SCAN   | issuing read addresses MIN_BIN..2^ADDR_W-1
// DRAIN  | waiting for in-flight reads to be compared
// FINISH | result registers valid, done pulse
module fft_peak_picker
  import fft_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          DATA_W      = 16,
  parameter int          BRAM_LAT    = 2,
  parameter int          MIN_BIN     = 1,
  parameter int unsigned NOISE_FLOOR = 64
) (
  input  logic              clk_104mhz,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] cur_fft,
  output logic [ADDR_W-1:0] read_addr,
  output logic              read_enable,
  output logic [ADDR_W:0]   largest_bucket,
  output logic [DATA_W-1:0] peak_mag,
  output logic              done,
  output logic              busy
);

  localparam int                 CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]   LAST_ADDR = CNT_W'((1 << ADDR_W) - 1);
  localparam logic [CNT_W-1:0]   FIRST     = CNT_W'(MIN_BIN);
  localparam logic [DATA_W-1:0]  FLOOR     = DATA_W'(NOISE_FLOOR);

  peak_state_t        r_state, w_state_nxt;
  logic               r_start_q;
  logic               r_start_edge;
  logic [CNT_W-1:0]   r_addr;
  logic [DATA_W-1:0]  r_best_mag;
  logic [ADDR_W-1:0]  r_best_idx;
  logic [ADDR_W:0]    r_largest;
  logic [DATA_W-1:0]  r_peak_mag;
  logic               r_done;

  logic               w_accept;
  logic               w_load;
  logic               w_pipe_valid;
  logic [ADDR_W-1:0]  w_pipe_addr;
  logic               w_pipe_busy;

  fft_delay_pipe #(
    .LAT (BRAM_LAT),
    .AW  (ADDR_W)
  ) u_pipe (
    .clk_104mhz (clk_104mhz),
    .rst_n      (rst_n),
    .i_valid    (read_enable),
    .i_addr     (read_addr),
    .o_valid    (w_pipe_valid),
    .o_addr     (w_pipe_addr),
    .o_busy     (w_pipe_busy)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_start_edge) begin
          w_state_nxt = SCAN;
          w_accept    = 1'b1;
        end
      end
      SCAN: begin
        if (r_addr == LAST_ADDR) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!w_pipe_busy) begin
          w_state_nxt = FINISH;
          w_load      = 1'b1;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_104mhz or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // edges seen outside IDLE (including the FINISH cycle) are dropped, not queued
  always_ff @(posedge clk_104mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q    <= 1'b0;
      r_start_edge <= 1'b0;
    end else begin
      r_start_q    <= start;
      r_start_edge <= start & ~r_start_q & (r_state == IDLE);
    end
  end

  always_ff @(posedge clk_104mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= FIRST;
    end else if (r_state == SCAN && r_addr != LAST_ADDR) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  // strict compare keeps the lowest index on ties
  always_ff @(posedge clk_104mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_best_mag <= '0;
      r_best_idx <= '0;
    end else if (w_accept) begin
      r_best_mag <= '0;
      r_best_idx <= '0;
    end else if (w_pipe_valid && cur_fft > r_best_mag) begin
      r_best_mag <= cur_fft;
      r_best_idx <= w_pipe_addr;
    end
  end

  always_ff @(posedge clk_104mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_largest  <= '0;
      r_peak_mag <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_load;
      if (w_load) begin
        if (r_best_mag < FLOOR) begin
          r_largest  <= (ADDR_W+1)'(NO_PEAK);
          r_peak_mag <= '0;
        end else begin
          r_largest  <= {1'b0, r_best_idx};
          r_peak_mag <= r_best_mag;
        end
      end
    end
  end

  assign read_addr      = r_addr[ADDR_W-1:0];
  assign read_enable    = (r_state == SCAN);
  assign largest_bucket = r_largest;
  assign peak_mag       = r_peak_mag;
  assign done           = r_done;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_fft_peak_picker.sv
// Directed bench: three picker builds (BRAM_LAT 1, 2, 3) share stimulus, each with its own BRAM read model.
module tb_fft_peak_picker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] mem [1024];

  logic [9:0]  ra   [3];
  logic        re   [3];
  logic [10:0] lb   [3];
  logic [15:0] pm   [3];
  logic        dn   [3];
  logic        bz   [3];
  logic [15:0] cur  [3];
  logic [15:0] bp   [3][3];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fft_peak_picker #(
      .ADDR_W(10), .DATA_W(16), .BRAM_LAT(g + 1), .MIN_BIN(1), .NOISE_FLOOR(64)
    ) u_dut (
      .clk_104mhz     (clk),
      .rst_n          (rst_n),
      .start          (start),
      .cur_fft        (cur[g]),
      .read_addr      (ra[g]),
      .read_enable    (re[g]),
      .largest_bucket (lb[g]),
      .peak_mag       (pm[g]),
      .done           (dn[g]),
      .busy           (bz[g])
    );
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bp[k][0] <= mem[ra[k]];
      bp[k][1] <= bp[k][0];
      bp[k][2] <= bp[k][1];
    end
  end
  assign cur[0] = bp[0][0];
  assign cur[1] = bp[1][1];
  assign cur[2] = bp[2][2];

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 1024; i++) mem[i] = v;
  endtask

  task automatic run_frame(input string name, input int exp_idx, input int exp_mag,
                           input int hold, input bit reedge);
    int done_at  [3];
    int done_cnt [3];
    for (int k = 0; k < 3; k++) begin
      done_at[k]  = -1;
      done_cnt[k] = 0;
    end
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (i == hold - 1) start = 1'b0;
      if (reedge && i == 200) start = 1'b1;
      if (reedge && i == 203) start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (i == 1) begin
          vectors++;
          if (ra[k] !== 10'd1 || re[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s first_addr dut%0d: got addr %0d en %0b expected 1 1", name, k, ra[k], re[k]);
          end
        end
        if (i == 10) begin
          vectors++;
          if (bz[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_mid dut%0d: got %0b expected 1", name, k, bz[k]);
          end
        end
        if (dn[k] === 1'b1) begin
          done_cnt[k]++;
          if (done_at[k] < 0) done_at[k] = i;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (done_at[k] != 1025 + k + 1) begin
        errors++;
        $display("FAIL %s done_cycle dut%0d: got %0d expected %0d", name, k, done_at[k], 1025 + k + 1);
      end
      vectors++;
      if (done_cnt[k] != 1) begin
        errors++;
        $display("FAIL %s done_count dut%0d: got %0d expected 1", name, k, done_cnt[k]);
      end
      vectors++;
      if (lb[k] !== 11'(exp_idx) || pm[k] !== 16'(exp_mag)) begin
        errors++;
        $display("FAIL %s result dut%0d: got idx %0d mag %0h expected idx %0d mag %0h",
                 name, k, lb[k], pm[k], exp_idx, exp_mag);
      end
      vectors++;
      if (bz[k] !== 1'b0 || ra[k] !== 10'd1023) begin
        errors++;
        $display("FAIL %s idle_hold dut%0d: got busy %0b addr %0d expected 0 1023", name, k, bz[k], ra[k]);
      end
    end
  endtask

  task automatic check_cleared(input string name);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (lb[k] !== 11'd0 || pm[k] !== 16'd0 || dn[k] !== 1'b0 || bz[k] !== 1'b0 ||
          re[k] !== 1'b0 || ra[k] !== 10'd0) begin
        errors++;
        $display("FAIL %s dut%0d: got idx %0d mag %0h done %0b busy %0b en %0b addr %0d expected all 0",
                 name, k, lb[k], pm[k], dn[k], bz[k], re[k], ra[k]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    fill(16'd0);
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_peak;
    fill(16'd5);
    mem[300] = 16'h0800;
    run_frame("single_peak", 300, 16'h0800, 1, 1'b0);
  endtask

  task automatic test_tie;
    fill(16'd5);
    mem[100] = 16'h1000;
    mem[700] = 16'h1000;
    run_frame("tie", 100, 16'h1000, 1, 1'b0);
  endtask

  task automatic test_noise_floor;
    fill(16'd5);
    mem[50] = 16'd40;
    run_frame("below_floor", 0, 0, 1, 1'b0);
    fill(16'd3);
    mem[900] = 16'd64;
    run_frame("at_floor", 900, 64, 1, 1'b0);
    fill(16'd0);
    run_frame("all_zero", 0, 0, 1, 1'b0);
  endtask

  task automatic test_last_bin_held_start;
    fill(16'd5);
    mem[0]    = 16'hFFFF;
    mem[1023] = 16'h2000;
    run_frame("last_bin", 1023, 16'h2000, 1024, 1'b0);
  endtask

  task automatic test_reset_mid_scan;
    fill(16'd5);
    mem[200] = 16'h0300;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_cleared("reset_mid_scan");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fill(16'd5);
    mem[300] = 16'h0800;
    run_frame("restart_reedge", 300, 16'h0800, 1, 1'b1);
  endtask

  task automatic test_finish_edge;
    bit fired = 1'b0;
    int after = 0;
    int busy_after = 0;
    int dones = 0;
    fill(16'd5);
    mem[600] = 16'h0700;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (fired && after < 6) begin
        after++;
        if (bz[1] === 1'b1) busy_after++;
      end
      if (dn[1] === 1'b1) begin
        dones++;
        if (!fired) begin
          fired = 1'b1;
          start = 1'b1;
        end
      end
    end
    vectors++;
    if (dones != 1 || busy_after != 0 || after != 6) begin
      errors++;
      $display("FAIL finish_edge dut1: got dones %0d busy_cycles %0d observed %0d expected 1 0 6",
               dones, busy_after, after);
    end
    vectors++;
    if (lb[1] !== 11'd600) begin
      errors++;
      $display("FAIL finish_edge_result dut1: got %0d expected 600", lb[1]);
    end
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset;
    test_single_peak;
    test_tie;
    test_noise_floor;
    test_last_bin_held_start;
    test_reset_mid_scan;
    test_finish_edge;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
